ddr3_client_arbiter: RTL and testbench
======================================

// Module: ddr3_client_arbiter
// PURPOSE
//  Two-client arbiter between the path-tracer framebuffer writer and the VGA framebuffer reader and the MIG DDR3 user port.
//  Serialises write/read commands onto one app_* interface and steers read returns to the reader.
//  Replaces the frame_complete address/cmd mux: interleaves both clients so display runs while rendering.
//  Read-priority, with a starvation guard for writes; tracks outstanding reads.
// PARAMETERS
//  ADDR_WIDTH       19  client address width; zero-extended to 28-bit app_addr
//  DATA_WIDTH       64  app_wdf_data / app_rd_data width
//  MAX_RD_BURST     16  max consecutive read grants while a write is pending
//  MAX_OUTSTANDING  32  max read commands accepted but not yet returned
// PORTS
//  clk              in   1   ddr3 ui_clk
//  arst             in   1   asynchronous reset, active-low
//  calib_done       in   1   DDR3 init_calib_complete; no grants while low
//  wr_req           in   1   writer: request held until wr_ack
//  wr_addr          in   ADDR_WIDTH  writer address, stable while wr_req
//  wr_data          in   DATA_WIDTH  writer data, stable while wr_req
//  wr_ack           out  1   1-cycle pulse: cmd and data both taken by MIG
//  rd_req           in   1   reader: request held until rd_ack
//  rd_addr          in   ADDR_WIDTH  reader address, stable while rd_req
//  rd_ack           out  1   1-cycle pulse: read cmd taken by MIG
//  rd_valid         out  1   read data valid to reader
//  rd_data          out  DATA_WIDTH  read data to reader
//  app_rdy          in   1   MIG cmd ready
//  app_wdf_rdy      in   1   MIG write-data ready
//  app_rd_data_valid in  1   MIG read data valid
//  app_rd_data      in   DATA_WIDTH  MIG read data
//  app_en           out  1   MIG cmd valid
//  app_cmd          out  3   3'b000 write, 3'b001 read
//  app_addr         out  28  {zeros, granted client addr}
//  app_wdf_wren     out  1   write data valid
//  app_wdf_end      out  1   equals app_wdf_wren (one beat per burst)
//  app_wdf_data     out  DATA_WIDTH  registered wr_data
//  rd_err           out  1   sticky: app_rd_data_valid with zero outstanding
// BEHAVIOUR
//  Reset (arst=0): FSM=IDLE; all outputs 0; counters 0; rd_err cleared. Only arst clears rd_err.
//  FSM IDLE: if !calib_done stay. Else pick READ if rd_req && outstanding<MAX_OUTSTANDING &&
//   !(wr_req && rd_streak==MAX_RD_BURST); else WRITE if wr_req; else stay. Decision registered.
//  RD_CMD: app_en=1, app_cmd=001, app_addr=rd_addr. On app_en&&app_rdy: rd_ack=1 next cycle, outstanding++,
//   rd_streak++ (saturating) if wr_req else 0; -> IDLE. Command never dropped while app_rdy=0.
//  WR: app_en=1/cmd=000 and app_wdf_wren=1 asserted together; each deasserts independently on its own
//   ready (app_rdy / app_wdf_rdy). Data may be taken before, with, or after the command.
//   When both taken: wr_ack=1 next cycle, rd_streak=0, -> IDLE.
//  Grant is registered: min 2 cycles from req to app_en; 1 cycle from acceptance to ack. Max one command per
//   2 cycles; throughput is not a goal.
//  Read return: rd_valid/rd_data = app_rd_data_valid/app_rd_data registered (1-cycle latency), in MIG order.
//  outstanding: +1 on read accept, -1 on app_rd_data_valid; both in same cycle -> unchanged.
//   At 0 with valid: rd_err=1, counter stays 0, data still forwarded.
//  calib_done falling mid-transaction: current command/data completes; no new grant until high.
//  Client drops req before ack: protocol violation; arbiter completes the transaction with captured addr/data.
//  wr_addr/wr_data/rd_addr captured at grant; later changes ignored.
// TESTING
//  calib_done=0, wr_req=rd_req=1 for 100 cycles -> app_en never 1, no acks.
//  Single write addr=0x10 data=0xDEAD, app_rdy=app_wdf_rdy=1 -> one app_en cmd=000 addr=0x10, one wr_ack.
//  Write with app_rdy held 0 for 5 cycles, app_wdf_rdy=1 -> wdf beat taken at once, cmd held 5 cycles,
//   exactly one wr_ack after cmd accept.
//  wr_req and rd_req held continuously -> exactly 16 rd_acks then 1 wr_ack, pattern repeats.
//  Stall MIG read returns, rd_req held -> 32 rd_acks then none until a app_rd_data_valid frees a slot.
//  app_rd_data_valid with zero outstanding -> rd_err=1 and stays 1 until arst.

Source files
------------

// File: rtl/ddr3_client_arbiter.sv
// rtl/ddr3_client_arbiter.sv - two-client (writer/reader) arbiter onto the MIG DDR3 app_* user port
//
// Purpose: serialises framebuffer-writer and display-reader commands onto one
// MIG app interface. Reads have priority, and a starvation guard forces a write
// through after MAX_RD_BURST consecutive reads. Read returns are forwarded in
// MIG order, and the number of reads in flight is tracked.
//
// Ports:
//   clk, arst (async, active-low), calib_done
//   writer: wr_req, wr_addr, wr_data -> wr_ack
//   reader: rd_req, rd_addr -> rd_ack; rd_valid, rd_data
//   MIG:    app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data ->
//           app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data
//   rd_err: sticky, read data returned with nothing outstanding

module ddr3_client_arbiter #(
  parameter int ADDR_WIDTH      = 19,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_RD_BURST    = 16,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  calib_done,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  app_rdy,
  input  logic                  app_wdf_rdy,
  input  logic                  app_rd_data_valid,
  input  logic [DATA_WIDTH-1:0] app_rd_data,
  output logic                  app_en,
  output logic [2:0]            app_cmd,
  output logic [27:0]           app_addr,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [DATA_WIDTH-1:0] app_wdf_data,
  output logic                  rd_err
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(MAX_RD_BURST + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_CMD = 2'd1,
    WR     = 2'd2
  } state_t;

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  cmd_taken, data_taken;
  logic [OW-1:0]         outstanding;
  logic [SW-1:0]         rd_streak;

  logic rd_pick, cmd_acc, data_acc, wr_done, rd_accept;
  logic grant_rd, grant_wr;

  // Command/data valids are pure functions of registered state.
  assign app_en       = (state == RD_CMD) || ((state == WR) && !cmd_taken);
  assign app_cmd      = (state == RD_CMD) ? 3'b001 : 3'b000;
  assign app_wdf_wren = (state == WR) && !data_taken;
  assign app_wdf_end  = app_wdf_wren;
  assign app_addr     = {{(28-ADDR_WIDTH){1'b0}}, addr_q};
  assign app_wdf_data = wdata_q;

  assign cmd_acc   = app_en && app_rdy;
  assign data_acc  = app_wdf_wren && app_wdf_rdy;
  assign wr_done   = (state == WR) && (cmd_taken || cmd_acc) && (data_taken || data_acc);
  assign rd_accept = (state == RD_CMD) && app_rdy;

  // Reads win unless the read slots are full or a waiting write has already
  // been passed over MAX_RD_BURST times in a row.
  assign rd_pick = rd_req && (outstanding < OW'(MAX_OUTSTANDING))
                   && !(wr_req && (rd_streak == SW'(MAX_RD_BURST)));

  assign grant_rd = (state == IDLE) && (next_state == RD_CMD);
  assign grant_wr = (state == IDLE) && (next_state == WR);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) state <= IDLE;
    else       state <= next_state;
  end

  // No decision is taken while an ack is being shown: the client still
  // holds its request during that cycle and must not be granted twice.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (calib_done && !rd_ack && !wr_ack) begin
          if (rd_pick)     next_state = RD_CMD;
          else if (wr_req) next_state = WR;
        end
      end
      RD_CMD:  if (app_rdy) next_state = IDLE;
      WR:      if (wr_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      cmd_taken   <= 1'b0;
      data_taken  <= 1'b0;
      rd_ack      <= 1'b0;
      wr_ack      <= 1'b0;
      rd_streak   <= '0;
      outstanding <= '0;
      rd_err      <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      if (grant_rd) addr_q <= rd_addr;
      if (grant_wr) begin
        addr_q  <= wr_addr;
        wdata_q <= wr_data;
      end

      // Command and data halves of a write complete independently.
      if (wr_done) begin
        cmd_taken  <= 1'b0;
        data_taken <= 1'b0;
      end else begin
        if (cmd_acc && (state == WR)) cmd_taken  <= 1'b1;
        if (data_acc)                 data_taken <= 1'b1;
      end

      rd_ack <= rd_accept;
      wr_ack <= wr_done;

      if (wr_done) begin
        rd_streak <= '0;
      end else if (rd_accept) begin
        if (!wr_req)                             rd_streak <= '0;
        else if (rd_streak != SW'(MAX_RD_BURST)) rd_streak <= rd_streak + SW'(1);
      end

      // A return with nothing in flight is flagged and not counted down,
      // so a concurrent accept still registers as one read in flight.
      if (app_rd_data_valid && (outstanding == '0)) rd_err <= 1'b1;
      if (rd_accept && !(app_rd_data_valid && (outstanding != '0)))
        outstanding <= outstanding + OW'(1);
      else if (!rd_accept && app_rd_data_valid && (outstanding != '0))
        outstanding <= outstanding - OW'(1);

      rd_valid <= app_rd_data_valid;
      rd_data  <= app_rd_data;
    end
  end

endmodule

// File: tb/tb_ddr3_client_arbiter.sv
// tb/tb_ddr3_client_arbiter.sv - directed self-checking bench for ddr3_client_arbiter

module tb_ddr3_client_arbiter;

  localparam int AW = 19;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          arst, calib_done;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, app_rd_data;
  logic          app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic          wr_ack, rd_ack, rd_valid, app_en, app_wdf_wren, app_wdf_end, rd_err;
  logic [DW-1:0] rd_data, app_wdf_data;
  logic [2:0]    app_cmd;
  logic [27:0]   app_addr;

  ddr3_client_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RD_BURST(16), .MAX_OUTSTANDING(32)
  ) dut (
    .clk(clk), .arst(arst), .calib_done(calib_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int n_rd_ack = 0, n_wr_ack = 0, n_cmd_acc = 0, n_wdf_acc = 0;
  int n_app_en = 0, n_rd_valid = 0, n_end_bad = 0;

  // Event counters sampled mid-cycle, when inputs and outputs are settled.
  always @(negedge clk) begin
    if (rd_ack === 1'b1) n_rd_ack++;
    if (wr_ack === 1'b1) n_wr_ack++;
    if (app_en === 1'b1) n_app_en++;
    if (app_en === 1'b1 && app_rdy) n_cmd_acc++;
    if (app_wdf_wren === 1'b1 && app_wdf_rdy) n_wdf_acc++;
    if (rd_valid === 1'b1) n_rd_valid++;
    if (app_wdf_end !== app_wdf_wren) n_end_bad++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      app_rd_data_valid = 1'b1;
      app_rd_data = 64'h1000 + 64'(i);
      step();
    end
    app_rd_data_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    arst = 1'b0; calib_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; app_rd_data = '0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0;
    step(); step(); step();
    n_cmp++; if (app_en !== 1'b0) begin n_err++; $display("FAIL reset_app_en: got %b want 0", app_en); end
    n_cmp++; if (app_wdf_wren !== 1'b0) begin n_err++; $display("FAIL reset_wren: got %b want 0", app_wdf_wren); end
    n_cmp++; if ({wr_ack, rd_ack, rd_valid, rd_err} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {wr_ack, rd_ack, rd_valid, rd_err}); end
    n_cmp++; if (app_addr !== 28'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", app_addr); end
    arst = 1'b1;
    step();
  endtask

  task automatic test_no_calib();
    int a0, r0, w0;
    a0 = n_app_en; r0 = n_rd_ack; w0 = n_wr_ack;
    calib_done = 1'b0; wr_req = 1'b1; rd_req = 1'b1; wr_addr = 19'h5; rd_addr = 19'h6;
    for (int i = 0; i < 100; i++) step();
    wr_req = 1'b0; rd_req = 1'b0;
    step();
    n_cmp++; if (n_app_en - a0 != 0) begin n_err++; $display("FAIL nocal_app_en: got %0d cycles want 0", n_app_en - a0); end
    n_cmp++; if ((n_rd_ack - r0) + (n_wr_ack - w0) != 0) begin n_err++; $display("FAIL nocal_acks: got %0d want 0", (n_rd_ack - r0) + (n_wr_ack - w0)); end
    calib_done = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    int c0, w0, d0;
    c0 = n_cmd_acc; w0 = n_wr_ack; d0 = n_wdf_acc;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    wr_addr = 19'h10; wr_data = 64'hDEAD; wr_req = 1'b1;
    step();
    n_cmp++; if ({app_en, app_wdf_wren} !== 2'b11) begin n_err++; $display("FAIL wr_en_wren: got %b want 11", {app_en, app_wdf_wren}); end
    n_cmp++; if (app_cmd !== 3'b000) begin n_err++; $display("FAIL wr_cmd: got %b want 000", app_cmd); end
    n_cmp++; if (app_addr !== 28'h10) begin n_err++; $display("FAIL wr_addr: got %h want 0000010", app_addr); end
    n_cmp++; if (app_wdf_data !== 64'hDEAD) begin n_err++; $display("FAIL wr_data: got %h want dead", app_wdf_data); end
    wr_addr = 19'h77; wr_data = 64'hBEEF;
    step();
    n_cmp++; if ({wr_ack, app_en} !== 2'b10) begin n_err++; $display("FAIL wr_ack_pulse: got %b want 10", {wr_ack, app_en}); end
    wr_req = 1'b0;
    step();
    n_cmp++; if (wr_ack !== 1'b0) begin n_err++; $display("FAIL wr_ack_width: got %b want 0", wr_ack); end
    for (int i = 0; i < 8; i++) step();
    n_cmp++; if (n_cmd_acc - c0 != 1) begin n_err++; $display("FAIL wr_cmd_count: got %0d want 1", n_cmd_acc - c0); end
    n_cmp++; if (n_wdf_acc - d0 != 1) begin n_err++; $display("FAIL wr_wdf_count: got %0d want 1", n_wdf_acc - d0); end
    n_cmp++; if (n_wr_ack - w0 != 1) begin n_err++; $display("FAIL wr_ack_count: got %0d want 1", n_wr_ack - w0); end
  endtask

  task automatic test_write_cmd_stall();
    int w0, d0, early;
    w0 = n_wr_ack; d0 = n_wdf_acc; early = 0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b1;
    wr_addr = 19'h20; wr_data = 64'h1234; wr_req = 1'b1;
    step();
    n_cmp++; if ({app_en, app_wdf_wren} !== 2'b11) begin n_err++; $display("FAIL stall_first: got %b want 11", {app_en, app_wdf_wren}); end
    for (int i = 2; i <= 5; i++) begin
      step();
      if (wr_ack !== 1'b0 || app_en !== 1'b1 || app_wdf_wren !== 1'b0) early++;
    end
    n_cmp++; if (early != 0) begin n_err++; $display("FAIL stall_hold: got %0d bad cycles want 0", early); end
    n_cmp++; if (n_wdf_acc - d0 != 1) begin n_err++; $display("FAIL stall_wdf_once: got %0d want 1", n_wdf_acc - d0); end
    app_rdy = 1'b1;
    step();
    n_cmp++; if ({wr_ack, app_en} !== 2'b10) begin n_err++; $display("FAIL stall_ack: got %b want 10", {wr_ack, app_en}); end
    wr_req = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_cmp++; if (n_wr_ack - w0 != 1) begin n_err++; $display("FAIL stall_ack_count: got %0d want 1", n_wr_ack - w0); end
  endtask

  task automatic test_write_data_late();
    app_rdy = 1'b1; app_wdf_rdy = 1'b0;
    wr_addr = 19'h30; wr_data = 64'h5678; wr_req = 1'b1;
    step();
    step();
    n_cmp++; if ({app_en, app_wdf_wren, wr_ack} !== 3'b010) begin n_err++; $display("FAIL late_cmd_first: got %b want 010", {app_en, app_wdf_wren, wr_ack}); end
    step();
    n_cmp++; if ({app_en, app_wdf_wren, wr_ack} !== 3'b010) begin n_err++; $display("FAIL late_hold: got %b want 010", {app_en, app_wdf_wren, wr_ack}); end
    app_wdf_rdy = 1'b1;
    step();
    n_cmp++; if ({wr_ack, app_wdf_wren} !== 2'b10) begin n_err++; $display("FAIL late_ack: got %b want 10", {wr_ack, app_wdf_wren}); end
    wr_req = 1'b0;
    step(); step();
    n_cmp++; if (n_end_bad != 0) begin n_err++; $display("FAIL wdf_end_tracks_wren: got %0d diffs want 0", n_end_bad); end
  endtask

  task automatic test_read_return();
    app_rdy = 1'b1;
    rd_addr = 19'h7FFFF; rd_req = 1'b1;
    step();
    n_cmp++; if ({app_en, app_cmd} !== 4'b1001) begin n_err++; $display("FAIL rd_cmd: got %b want 1001", {app_en, app_cmd}); end
    n_cmp++; if (app_addr !== 28'h007FFFF) begin n_err++; $display("FAIL rd_addr_max: got %h want 007ffff", app_addr); end
    step();
    n_cmp++; if (rd_ack !== 1'b1) begin n_err++; $display("FAIL rd_ack: got %b want 1", rd_ack); end
    rd_req = 1'b0;
    app_rd_data_valid = 1'b1; app_rd_data = 64'hCAFE_F00D_0123_4567;
    step();
    app_rd_data_valid = 1'b0;
    n_cmp++; if ({rd_valid, rd_data} !== {1'b1, 64'hCAFE_F00D_0123_4567}) begin n_err++; $display("FAIL rd_return: got %b %h want 1 cafef00d01234567", rd_valid, rd_data); end
    step();
    n_cmp++; if ({rd_valid, rd_err} !== 2'b00) begin n_err++; $display("FAIL rd_return_end: got %b want 00", {rd_valid, rd_err}); end
  endtask

  task automatic test_arbitration();
    logic got_w [0:33];
    int   seq_n, v0;
    seq_n = 0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    rd_addr = 19'h1; wr_addr = 19'h2; wr_data = 64'hAA;
    rd_req = 1'b1; wr_req = 1'b1;
    for (int c = 0; c < 400 && seq_n < 34; c++) begin
      step();
      if (rd_ack === 1'b1 || wr_ack === 1'b1) begin
        got_w[seq_n] = wr_ack;
        seq_n++;
        if (seq_n == 34) begin rd_req = 1'b0; wr_req = 1'b0; end
      end
    end
    rd_req = 1'b0; wr_req = 1'b0;
    n_cmp++; if (seq_n != 34) begin n_err++; $display("FAIL arb_ack_total: got %0d want 34 within budget", seq_n); end
    for (int k = 0; k < seq_n; k++) begin
      n_cmp++;
      if (got_w[k] !== ((k == 16) || (k == 33))) begin
        n_err++; $display("FAIL arb_seq[%0d]: got %s want %s", k, got_w[k] ? "W" : "R", ((k == 16) || (k == 33)) ? "W" : "R");
      end
    end
    step(); step();
    v0 = n_rd_valid;
    drain(32);
    n_cmp++; if (n_rd_valid - v0 != 32) begin n_err++; $display("FAIL arb_drain: got %0d want 32", n_rd_valid - v0); end
    n_cmp++; if (rd_err !== 1'b0) begin n_err++; $display("FAIL arb_no_err: got %b want 0", rd_err); end
  endtask

  task automatic test_outstanding_limit();
    int r0;
    r0 = n_rd_ack;
    app_rdy = 1'b1; rd_addr = 19'h40; rd_req = 1'b1;
    for (int i = 0; i < 150; i++) step();
    n_cmp++; if (n_rd_ack - r0 != 32) begin n_err++; $display("FAIL limit_acks: got %0d want 32", n_rd_ack - r0); end
    n_cmp++; if (app_en !== 1'b0) begin n_err++; $display("FAIL limit_idle: got %b want 0", app_en); end
    app_rd_data_valid = 1'b1; app_rd_data = 64'h99;
    step();
    app_rd_data_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    rd_req = 1'b0;
    step();
    n_cmp++; if (n_rd_ack - r0 != 33) begin n_err++; $display("FAIL limit_one_slot: got %0d want 33", n_rd_ack - r0); end
    drain(32);
    n_cmp++; if (rd_err !== 1'b0) begin n_err++; $display("FAIL limit_no_err: got %b want 0", rd_err); end
  endtask

  task automatic test_calib_drop();
    int a0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b1;
    wr_addr = 19'h33; wr_data = 64'h33; wr_req = 1'b1;
    step();
    n_cmp++; if (app_en !== 1'b1) begin n_err++; $display("FAIL cdrop_start: got %b want 1", app_en); end
    calib_done = 1'b0;
    step(); step();
    app_rdy = 1'b1;
    step();
    n_cmp++; if (wr_ack !== 1'b1) begin n_err++; $display("FAIL cdrop_complete: got %b want 1", wr_ack); end
    a0 = n_app_en;
    rd_req = 1'b1;
    for (int i = 0; i < 20; i++) step();
    wr_req = 1'b0; rd_req = 1'b0;
    step();
    n_cmp++; if (n_app_en - a0 != 0) begin n_err++; $display("FAIL cdrop_no_grant: got %0d want 0", n_app_en - a0); end
    calib_done = 1'b1;
    step();
  endtask

  task automatic test_rd_err();
    n_cmp++; if (rd_err !== 1'b0) begin n_err++; $display("FAIL err_pre: got %b want 0", rd_err); end
    app_rd_data_valid = 1'b1; app_rd_data = 64'h55AA;
    step();
    app_rd_data_valid = 1'b0;
    n_cmp++; if ({rd_valid, rd_data, rd_err} !== {1'b1, 64'h55AA, 1'b1}) begin n_err++; $display("FAIL err_set: got %b %h %b want 1 55aa 1", rd_valid, rd_data, rd_err); end
    for (int i = 0; i < 10; i++) step();
    n_cmp++; if (rd_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", rd_err); end
    arst = 1'b0;
    #1;
    n_cmp++; if (rd_err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b want 0", rd_err); end
    step();
    arst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_no_calib();
    test_single_write();
    test_write_cmd_stall();
    test_write_data_late();
    test_read_return();
    test_arbitration();
    test_outstanding_limit();
    test_calib_drop();
    test_rd_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
